// File: rtl/alu_driver_accu_pkg.sv
// ---------------------------------------------------------------------------
// alu_driver_accu_pkg
//   Shared definitions for the lab CPU accumulator datapath.
//   - OP_W             : width of the ALU opcode field
//   - OP_PASS_A .. OP_NAND : ALU operation encodings
//   Opcodes 3'b101..3'b111 are unassigned; the ALU returns zero for them.
// ---------------------------------------------------------------------------
package alu_driver_accu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_PASS_A = 3'b000;
  localparam logic [OP_W-1:0] OP_CMP    = 3'b001;
  localparam logic [OP_W-1:0] OP_PASS_B = 3'b010;
  localparam logic [OP_W-1:0] OP_ADD    = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND   = 3'b100;

endpackage : alu_driver_accu_pkg

// File: rtl/alu_driver_accu_alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU of the accumulator datapath.
//   Ports:
//     a      : operand A (accumulator)
//     b      : operand B (internal bus)
//     opcode : operation select (see alu_driver_accu_pkg)
//     result : WIDTH-bit result, modulo 2^WIDTH
//     Carry  : carry-out for add, borrow (a < b) for compare, else 0
//     Zero   : result == 0, for every opcode
// ---------------------------------------------------------------------------
module alu_core
  import alu_driver_accu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  opcode,
  output logic [WIDTH-1:0] result,
  output logic             Carry,
  output logic             Zero
);

  // One bit wider than the datapath so the MSB carries the carry/borrow.
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    // MSB of the zero-extended difference is set exactly when a < b.
    diff_ext = {1'b0, a} - {1'b0, b};
  end

  always_comb begin
    result = '0;
    Carry  = 1'b0;
    case (opcode)
      OP_PASS_A: result = a;
      OP_CMP: begin
        result = diff_ext[WIDTH-1:0];
        Carry  = diff_ext[WIDTH];
      end
      OP_PASS_B: result = b;
      OP_ADD: begin
        result = sum_ext[WIDTH-1:0];
        Carry  = sum_ext[WIDTH];
      end
      OP_NAND: result = ~(a & b);
      default: begin
        result = '0;
        Carry  = 1'b0;
      end
    endcase
  end

  always_comb begin
    Zero = (result == '0);
  end

endmodule : alu_core

// File: rtl/alu_driver_accu.sv
// ---------------------------------------------------------------------------
// alu_driver_accu
//   4-bit accumulator datapath for the lab CPU.
//   Ports:
//     clk     : system clock, accumulator updates on rising edge
//     rst     : asynchronous active-high reset, clears the accumulator
//     in      : external operand, placed on the internal bus when en1=1
//     en_accu : accumulator load enable
//     en1     : input driver enable (in -> ALU operand B); bus reads 0 if off
//     en2     : output driver enable (ALU result -> out); out is Z if off
//     opcode  : ALU operation select
//     Carry   : ALU carry/borrow flag, combinational, never tristated
//     Zero    : ALU zero flag, combinational, never tristated
//     out     : tristated ALU result
// ---------------------------------------------------------------------------
module alu_driver_accu
  import alu_driver_accu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             en_accu,
  input  logic             en1,
  input  logic             en2,
  input  logic [OP_W-1:0]  opcode,
  output logic             Carry,
  output logic             Zero,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_result;

  // Input driver: the internal bus is pulled down when not driven, so the
  // ALU never sees an undriven operand.
  always_comb begin
    operand_b = en1 ? in : '0;
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a      (acc_q),
    .b      (operand_b),
    .opcode (opcode),
    .result (alu_result),
    .Carry  (Carry),
    .Zero   (Zero)
  );

  always_comb begin
    acc_d = en_accu ? alu_result : acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Output driver.
  assign out = en2 ? alu_result : {WIDTH{1'bz}};

endmodule : alu_driver_accu

// File: tb/tb_alu_driver_accu.sv
// ---------------------------------------------------------------------------
// tb_alu_driver_accu
//   Directed bench for alu_driver_accu. The out bus carries pull-ups so a
//   released bus reads as 4'b1111; those checks use opcodes whose driven
//   result differs from 1111.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_driver_accu;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic       en_accu;
  logic       en1;
  logic       en2;
  logic [2:0] opcode;
  logic       carry_w;
  logic       zero_w;
  wire  [3:0] out_w;

  pullup (out_w[0]);
  pullup (out_w[1]);
  pullup (out_w[2]);
  pullup (out_w[3]);

  int unsigned tests_run;
  int unsigned tests_failed;

  alu_driver_accu #(
    .WIDTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .en_accu (en_accu),
    .en1     (en1),
    .en2     (en2),
    .opcode  (opcode),
    .Carry   (carry_w),
    .Zero    (zero_w),
    .out     (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] din,
                       input logic ea, input logic e1, input logic e2);
    opcode  = op;
    in      = din;
    en_accu = ea;
    en1     = e1;
    en2     = e2;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    drive(3'b000, 4'b0111, 1'b0, 1'b0, 1'b0);

    // Reset, enables off.
    tick();
    chk("rst_acc", {4'b0, dut.acc_q}, 8'h00);
    rst = 1'b0;
    tick();
    chk("off_out_released", {4'b0, out_w}, 8'h0F);
    chk("off_zero", {7'b0, zero_w}, 8'h01);
    chk("off_carry", {7'b0, carry_w}, 8'h00);
    chk("off_acc", {4'b0, dut.acc_q}, 8'h00);

    // Pass A, then pass B.
    drive(3'b000, 4'b0111, 1'b1, 1'b1, 1'b1);
    chk("pass_a_out", {4'b0, out_w}, 8'h00);
    chk("pass_a_zero", {7'b0, zero_w}, 8'h01);
    drive(3'b010, 4'b0001, 1'b1, 1'b1, 1'b1);
    chk("pass_b_out", {4'b0, out_w}, 8'h01);
    chk("pass_b_zero", {7'b0, zero_w}, 8'h00);
    tick();
    chk("pass_b_acc", {4'b0, dut.acc_q}, 8'h01);

    // Compare with borrow.
    drive(3'b001, 4'b1001, 1'b1, 1'b1, 1'b1);
    chk("cmp_out", {4'b0, out_w}, 8'h08);
    chk("cmp_carry", {7'b0, carry_w}, 8'h01);
    tick();
    chk("cmp2_acc", {4'b0, dut.acc_q}, 8'h08);
    chk("cmp2_out", {4'b0, out_w}, 8'h0F);
    chk("cmp2_carry", {7'b0, carry_w}, 8'h01);
    chk("cmp2_zero", {7'b0, zero_w}, 8'h00);

    // Add with carry-out, then without.
    drive(3'b011, 4'b1011, 1'b1, 1'b1, 1'b1);
    chk("add_out", {4'b0, out_w}, 8'h03);
    chk("add_carry", {7'b0, carry_w}, 8'h01);
    tick();
    chk("add2_acc", {4'b0, dut.acc_q}, 8'h03);
    chk("add2_out", {4'b0, out_w}, 8'h0E);
    chk("add2_carry", {7'b0, carry_w}, 8'h00);
    tick();
    chk("add3_acc", {4'b0, dut.acc_q}, 8'h0E);

    // NAND.
    drive(3'b100, 4'b1010, 1'b1, 1'b1, 1'b1);
    chk("nand_out", {4'b0, out_w}, 8'h05);
    chk("nand_carry", {7'b0, carry_w}, 8'h00);
    tick();
    chk("nand2_acc", {4'b0, dut.acc_q}, 8'h05);
    chk("nand2_out", {4'b0, out_w}, 8'h0F);

    // Enables off: acc holds, out released, flags still live.
    drive(3'b000, 4'b1010, 1'b0, 1'b0, 1'b0);
    chk("hold_out_released", {4'b0, out_w}, 8'h0F);
    chk("hold_zero", {7'b0, zero_w}, 8'h00);
    tick();
    tick();
    chk("hold_acc", {4'b0, dut.acc_q}, 8'h05);
    drive(3'b000, 4'b1010, 1'b0, 1'b0, 1'b1);
    chk("hold_out_driven", {4'b0, out_w}, 8'h05);

    // Unassigned opcodes return zero.
    drive(3'b101, 4'b0011, 1'b0, 1'b1, 1'b1);
    chk("op5_out", {4'b0, out_w}, 8'h00);
    chk("op5_zero", {7'b0, zero_w}, 8'h01);
    drive(3'b111, 4'b1111, 1'b0, 1'b1, 1'b1);
    chk("op7_out", {4'b0, out_w}, 8'h00);
    chk("op7_carry", {7'b0, carry_w}, 8'h00);

    // Compare equal: no borrow, zero result. Add wrap to zero.
    drive(3'b001, 4'b0101, 1'b0, 1'b1, 1'b1);
    chk("cmp_eq_out", {4'b0, out_w}, 8'h00);
    chk("cmp_eq_carry", {7'b0, carry_w}, 8'h00);
    chk("cmp_eq_zero", {7'b0, zero_w}, 8'h01);
    drive(3'b011, 4'b1011, 1'b0, 1'b1, 1'b1);
    chk("add_wrap_out", {4'b0, out_w}, 8'h00);
    chk("add_wrap_carry", {7'b0, carry_w}, 8'h01);
    chk("add_wrap_zero", {7'b0, zero_w}, 8'h01);
    // en1 off: B reads as zero.
    drive(3'b010, 4'b1011, 1'b0, 1'b0, 1'b1);
    chk("bus_pulldown", {4'b0, out_w}, 8'h00);

    // Async reset between edges.
    @(negedge clk);
    drive(3'b000, 4'b0110, 1'b1, 1'b1, 1'b1);
    chk("pre_rst_out", {4'b0, out_w}, 8'h05);
    rst = 1'b1;
    #1;
    chk("arst_acc", {4'b0, dut.acc_q}, 8'h00);
    chk("arst_out", {4'b0, out_w}, 8'h00);
    chk("arst_zero", {7'b0, zero_w}, 8'h01);
    // Clock edge while reset is held must not load.
    drive(3'b010, 4'b0101, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rst_edge_acc", {4'b0, dut.acc_q}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    chk("post_rst_acc", {4'b0, dut.acc_q}, 8'h00);
    chk("post_rst_out", {4'b0, out_w}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_alu_driver_accu
